// File: rtl/color_manager_window_counter.sv
// -----------------------------------------------------------------------------
// color_manager_window_counter
//
// Two-axis active-window counter for the Color Manager. Tracks the horizontal
// and vertical position inside the sync-generator timing, qualifies the pixels
// that fall strictly inside both porch windows, and produces the pixel X/Y
// coordinates of the active picture for the colour pipeline.
//
// Parameters
//   H_WIDTH      width of horizontal porches, H counter and CounterX
//   V_WIDTH      width of vertical porches, V counter and CounterY
//
// Ports
//   Clk            in   rising-edge clock
//   Rst            in   synchronous, active-high reset
//   HSync          in   high while a line is in progress
//   VSync          in   high while a frame is in progress
//   HBackPorch     in   horizontal lower bound (exclusive)
//   HFrontPorch    in   horizontal upper bound (exclusive)
//   VBackPorch     in   vertical lower bound (exclusive)
//   VFrontPorch    in   vertical upper bound (exclusive)
//   Counter_Valid  out  registered: X/Y are inside the active window
//   CounterX       out  pixel index within the active line
//   CounterY       out  active line index within the frame
//   Line_Start     out  one-cycle pulse when Counter_Valid rises
//   Frame_Start    out  one-cycle pulse at the first active pixel of a frame
//
// Optional feature
//   CM_WINDOW_EDGE_PULSE_EN  when defined, adds Line_Start / Frame_Start.
// -----------------------------------------------------------------------------
module color_manager_window_counter #(
  parameter int H_WIDTH = 12,
  parameter int V_WIDTH = 11
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               HSync,
  input  logic               VSync,
  input  logic [H_WIDTH-1:0] HBackPorch,
  input  logic [H_WIDTH-1:0] HFrontPorch,
  input  logic [V_WIDTH-1:0] VBackPorch,
  input  logic [V_WIDTH-1:0] VFrontPorch,
  output logic               Counter_Valid,
  output logic [H_WIDTH-1:0] CounterX,
  output logic [V_WIDTH-1:0] CounterY
`ifdef CM_WINDOW_EDGE_PULSE_EN
  ,
  output logic               Line_Start,
  output logic               Frame_Start
`endif
);

  localparam logic [H_WIDTH-1:0] H_ONE = {{(H_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [V_WIDTH-1:0] V_ONE = {{(V_WIDTH-1){1'b0}}, 1'b1};

  // Raw position counters and bookkeeping flags
  logic [H_WIDTH-1:0] r_h_int;
  logic [V_WIDTH-1:0] r_v_int;
  logic               r_hsync_d;
  logic               r_line_had_valid;
  logic               r_frame_active_seen;  // an active line has completed this frame

  logic               w_line_end;
  logic               w_hwin;
  logic               w_vwin;
  logic               w_valid_nxt;
  logic [H_WIDTH-1:0] w_h_int_nxt;
  logic [V_WIDTH-1:0] w_v_int_nxt;
  logic [H_WIDTH-1:0] w_x_nxt;
  logic [V_WIDTH-1:0] w_y_nxt;
  logic               w_line_had_valid_nxt;
  logic               w_frame_active_seen_nxt;

  // Falling edge of HSync marks the end of a line.
  assign w_line_end = r_hsync_d & ~HSync;

  // Window tests use the pre-increment counter values, so the porches refer to
  // the same sample index the counter shows this cycle.
  assign w_hwin = (HBackPorch < r_h_int) && (r_h_int < HFrontPorch);
  assign w_vwin = (VBackPorch < r_v_int) && (r_v_int < VFrontPorch);

  assign w_valid_nxt = HSync & VSync & w_hwin & w_vwin;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_h_int_nxt             = '0;
    w_v_int_nxt             = r_v_int;
    w_x_nxt                 = '0;
    w_y_nxt                 = CounterY;
    w_line_had_valid_nxt    = r_line_had_valid;
    w_frame_active_seen_nxt = r_frame_active_seen;

    // H counter saturates so an over-long line can never wrap back into the window.
    if (HSync && !(&r_h_int)) begin
      w_h_int_nxt = r_h_int + H_ONE;
    end else if (HSync) begin
      w_h_int_nxt = r_h_int;
    end

    // CounterX restarts at every rising edge of valid.
    if (w_valid_nxt && Counter_Valid) begin
      w_x_nxt = CounterX + H_ONE;
    end

    if (w_valid_nxt) begin
      w_line_had_valid_nxt = 1'b1;
    end

    // VSync low dominates every vertical update in the same cycle.
    if (!VSync) begin
      w_v_int_nxt             = '0;
      w_y_nxt                 = '0;
      w_line_had_valid_nxt    = 1'b0;
      w_frame_active_seen_nxt = 1'b0;
    end else if (w_line_end) begin
      if (!(&r_v_int)) begin
        w_v_int_nxt = r_v_int + V_ONE;
      end
      w_line_had_valid_nxt = 1'b0;
      // The first completed active line only arms the flag, which keeps the
      // first active line at Y=0.
      if (r_line_had_valid) begin
        w_frame_active_seen_nxt = 1'b1;
        if (r_frame_active_seen) begin
          w_y_nxt = CounterY + V_ONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_h_int             <= '0;
      r_v_int             <= '0;
      r_hsync_d           <= 1'b0;
      r_line_had_valid    <= 1'b0;
      r_frame_active_seen <= 1'b0;
      Counter_Valid       <= 1'b0;
      CounterX            <= '0;
      CounterY            <= '0;
    end else begin
      r_h_int             <= w_h_int_nxt;
      r_v_int             <= w_v_int_nxt;
      r_hsync_d           <= HSync;
      r_line_had_valid    <= w_line_had_valid_nxt;
      r_frame_active_seen <= w_frame_active_seen_nxt;
      Counter_Valid       <= w_valid_nxt;
      CounterX            <= w_x_nxt;
      CounterY            <= w_y_nxt;
    end
  end

`ifdef CM_WINDOW_EDGE_PULSE_EN
  logic w_valid_rise;

  assign w_valid_rise = w_valid_nxt & ~Counter_Valid;

  // Frame_Start needs no active line seen yet, neither completed nor in progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Line_Start  <= 1'b0;
      Frame_Start <= 1'b0;
    end else begin
      Line_Start  <= w_valid_rise;
      Frame_Start <= w_valid_rise & (CounterY == '0) &
                     ~r_frame_active_seen & ~r_line_had_valid;
    end
  end
`endif

endmodule

// File: doc/color_manager_window_counter.md
# color_manager_window_counter

Two-axis active-window counter for the Color Manager. It generalises the single-axis porch counter to horizontal and vertical axes with independent porch windows and parametrised widths. It also adds a saturating internal count, line and frame indices, and optional start pulses. It sits between the sync generator and the colour pipeline, and supplies pixel X/Y coordinates plus a qualifying valid flag.

## Interface
- `H_WIDTH`, default 12: width of horizontal porch inputs, H internal counter and `CounterX`.
- `V_WIDTH`, default 11: width of vertical porch inputs, V internal counter and `CounterY`.
- `Clk`  in  1  clock. All logic on rising edge.
- `Rst`  in  1  reset. Synchronous, active-high.
- `HSync`  in  1  line-active. High = line in progress; low = horizontal blanking.
- `VSync`  in  1  frame-active. High = frame in progress; low = vertical blanking.
- `HBackPorch`  in  `H_WIDTH`  horizontal lower bound (exclusive).
- `HFrontPorch`  in  `H_WIDTH`  horizontal upper bound (exclusive).
- `VBackPorch`  in  `V_WIDTH`  vertical lower bound (exclusive).
- `VFrontPorch`  in  `V_WIDTH`  vertical upper bound (exclusive).
- `Counter_Valid`  out  1  registered; current X/Y are inside the active window.
- `CounterX`  out  `H_WIDTH`  pixel index within the active line, starting at 0.
- `CounterY`  out  `V_WIDTH`  active line index within the frame, starting at 0.
- `Line_Start`  out  1  present only with `CM_WINDOW_EDGE_PULSE_EN`.
- `Frame_Start`  out  1  present only with `CM_WINDOW_EDGE_PULSE_EN`.

## Operation
- **Reset.** All registers clear to 0: H_int, V_int, HSync_d, line_had_valid, and all outputs.
- **H_int.**
  - `HSync`=0: H_int ← 0.
  - `HSync`=1: H_int ← H_int+1, saturating at all-ones; no wrap.
- **Line-end event.** `HSync_d`=1 and `HSync`=0, where `HSync_d` is `HSync` registered one cycle.
- **V_int.**
  - `VSync`=0: V_int ← 0.
  - Otherwise, on a line-end event: V_int ← V_int+1, saturating.
- **Window tests.** Unsigned, strict, evaluated on the current (pre-increment) register values.
  - hwin = HBackPorch < H_int < HFrontPorch.
  - vwin = VBackPorch < V_int < VFrontPorch.
- **Valid.** valid_nxt = `HSync` & `VSync` & hwin & vwin. `Counter_Valid` ← valid_nxt.
- **CounterX.**
  - valid_nxt=1 and `Counter_Valid`=1: `CounterX`+1.
  - valid_nxt=1 and `Counter_Valid`=0: 0.
  - valid_nxt=0: 0.
- **line_had_valid.** Set when valid_nxt=1. Cleared on a line-end event and when `VSync`=0.
- **CounterY.**
  - `VSync`=0: 0.
  - Line-end event with line_had_valid=1 and at least one completed active line this frame: `CounterY`+1.
  - Otherwise hold.
  - Implemented with a frame_active_seen flag, so the first active line is Y=0.
- **Degenerate porches.** HFrontPorch ≤ HBackPorch+1 or VFrontPorch ≤ VBackPorch+1: `Counter_Valid` never asserts, X/Y stay 0.
- **Simultaneous events.** `VSync` low dominates every V/Y update in the same cycle. `HSync` low with a line-end event: H_int clears and V_int increments in the same cycle.
- **Porch changes.** Porch inputs are sampled every cycle; changing them mid-line takes effect on the next cycle's comparison.

## Timing
- Latency is 1 cycle: the input sample producing valid_nxt appears on `Counter_Valid`/`CounterX` after the next rising edge.
- With `HSync` rising at sample 0, H_int=k at sample k. The first valid pixel is visible after the edge at sample HBackPorch+1.
- `CounterY` updates on the edge of the line-end sample, before the next line's first valid pixel.
- `Rst` asserted mid-line: all outputs are 0 after the next edge regardless of syncs. Counting restarts from the current `HSync`/`VSync` levels, treated as a fresh line/frame.

## Configuration
- Macro: `CM_WINDOW_EDGE_PULSE_EN`.
- **Defined.** `Line_Start` and `Frame_Start` ports exist. Both are registered single-cycle pulses and clear on reset.
  - `Line_Start`=1 on the cycle `Counter_Valid` rises.
  - `Frame_Start`=1 on the cycle `Counter_Valid` rises with `CounterY`=0 and no prior active line this frame.
- **Undefined.** Both ports and their logic are absent; all other behaviour is identical.

## Test plan
- **Basic line.** HBP=2, HFP=7, VBP=0, VFP=3, `VSync`=1, V_int=1, `HSync` high for 10 cycles. Response: `Counter_Valid` high for exactly 4 cycles, `CounterX`=0,1,2,3, then 0.
- **Frame of lines.** Same porches, `VSync` high, 4 lines of 10 cycles separated by 2 low cycles. Response: lines with V_int 1 and 2 are valid with `CounterY`=0 then 1; line V_int=3 is invalid; `CounterY` holds 1 until `VSync` drops, then 0.
- **Degenerate.** HBP=5, HFP=6 over a full frame. Response: `Counter_Valid` never asserts; X=Y=0.
- **Saturation.** `H_WIDTH`=4, HBP=0, HFP=15, `HSync` high 40 cycles. Response: H_int stops at 15; valid for 14 cycles (X 0..13), then low and stays low.
- **Reset mid-line.** `Rst` pulsed at X=2 during a valid line. Response: next cycle all outputs 0; with `HSync` still high, valid resumes after HBP+1 further samples with X=0.
- **Pulses (macro on).** Basic frame test. Response: `Frame_Start` once at the first valid pixel of Y=0; `Line_Start` once per active line (2 pulses).
